// File: rtl/wb_trace_checker.sv
// Golden-trace checker: serializes N-lane writebacks into a commit FIFO and compares them
// one per cycle against a reference stream, latching the first mismatch and the end PC.
module wb_trace_checker #(
  parameter int          LANES     = 2,
  parameter int          DEPTH     = 8,
  parameter logic [31:0] SKIP_BASE = 32'hbfc00380,
  parameter logic [31:0] SKIP_MASK = 32'hfffffff8,
  parameter logic [31:0] END_PC    = 32'hbfc00100
) (
  input  logic                sys_clk,
  input  logic                resetn,
  input  logic                trace_en,
  input  logic [LANES-1:0]    wb_en,
  input  logic [32*LANES-1:0] wb_pc,
  input  logic [5*LANES-1:0]  wb_rd,
  input  logic [32*LANES-1:0] wb_wdata,
  output logic                cpu_stall,
  input  logic                ref_valid,
  output logic                ref_ready,
  input  logic [31:0]         ref_pc,
  input  logic [4:0]          ref_rd,
  input  logic [31:0]         ref_wdata,
  output logic                err,
  output logic [1:0]          err_lane,
  output logic [31:0]         err_pc,
  output logic [4:0]          err_rd,
  output logic [31:0]         err_wdata,
  output logic [31:0]         err_ref_pc,
  output logic                done,
  output logic                overflow,
  output logic [31:0]         checked_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0] lane_pc    [LANES];
  logic [4:0]  lane_rd    [LANES];
  logic [31:0] lane_wdata [LANES];

  genvar gi;
  generate
    for (gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_pc[gi]    = wb_pc[32*gi +: 32];
      assign lane_rd[gi]    = wb_rd[5*gi +: 5];
      assign lane_wdata[gi] = wb_wdata[32*gi +: 32];
    end
  endgenerate

  logic [1:0]  mem_lane  [DEPTH];
  logic [31:0] mem_pc    [DEPTH];
  logic [4:0]  mem_rd    [DEPTH];
  logic [31:0] mem_wdata [DEPTH];

  logic [AW-1:0] head_reg;
  logic [AW-1:0] tail_reg;
  logic [CW-1:0] occ_reg;

  logic          halted;
  logic [CW-1:0] free_slots;
  logic [CW-1:0] push_cnt;
  logic          drop;
  logic          push_en  [LANES];
  logic [AW-1:0] push_idx [LANES];

  assign halted     = err | done;
  assign free_slots = CW'(DEPTH) - occ_reg;

  // Enabled lanes take consecutive tail slots in lane order; those beyond free space are dropped.
  always_comb begin
    push_cnt = '0;
    drop     = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      push_en[i]  = 1'b0;
      push_idx[i] = '0;
      if (wb_en[i] && !halted) begin
        if (push_cnt < free_slots) begin
          push_en[i]  = 1'b1;
          push_idx[i] = tail_reg + push_cnt[AW-1:0];
          push_cnt    = push_cnt + 1'b1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (push_en[i]) begin
        mem_lane[push_idx[i]]  <= 2'(i);
        mem_pc[push_idx[i]]    <= lane_pc[i];
        mem_rd[push_idx[i]]    <= lane_rd[i];
        mem_wdata[push_idx[i]] <= lane_wdata[i];
      end
    end
  end

  // Head is read combinationally so it can be compared in the cycle it is popped.
  logic [1:0]  head_lane;
  logic [31:0] head_pc;
  logic [4:0]  head_rd;
  logic [31:0] head_wdata;
  logic        mismatch;
  logic        skip_hit;
  logic        flag_err;
  logic        is_end;

  assign head_lane  = mem_lane[head_reg];
  assign head_pc    = mem_pc[head_reg];
  assign head_rd    = mem_rd[head_reg];
  assign head_wdata = mem_wdata[head_reg];

  assign mismatch  = (head_rd != ref_rd) | (head_wdata != ref_wdata) | (head_pc != ref_pc);
  assign skip_hit  = (head_pc & SKIP_MASK) == SKIP_BASE;
  assign flag_err  = mismatch & trace_en & !skip_hit;
  assign is_end    = ref_pc == END_PC;

  assign ref_ready = ref_valid & (occ_reg != '0) & !halted;
  assign cpu_stall = !halted & (occ_reg > CW'(DEPTH - LANES));

  always_ff @(posedge sys_clk) begin
    if (!resetn) begin
      head_reg      <= '0;
      tail_reg      <= '0;
      occ_reg       <= '0;
      err           <= 1'b0;
      err_lane      <= '0;
      err_pc        <= '0;
      err_rd        <= '0;
      err_wdata     <= '0;
      err_ref_pc    <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      checked_count <= '0;
    end else if (halted) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= '0;
    end else begin
      tail_reg <= tail_reg + push_cnt[AW-1:0];
      head_reg <= head_reg + AW'(ref_ready);
      occ_reg  <= occ_reg + push_cnt - CW'(ref_ready);
      if (drop) begin
        overflow <= 1'b1;
      end
      if (ref_ready) begin
        if (is_end) begin
          done <= 1'b1;
        end else begin
          if (checked_count != 32'hffffffff) begin
            checked_count <= checked_count + 32'd1;
          end
          if (flag_err) begin
            err        <= 1'b1;
            err_lane   <= head_lane;
            err_pc     <= head_pc;
            err_rd     <= head_rd;
            err_wdata  <= head_wdata;
            err_ref_pc <= ref_pc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_trace_checker.sv
// Directed bench for wb_trace_checker: fixed commit/reference sequences with hand-computed results.
module tb_wb_trace_checker;

  logic        sys_clk = 1'b0;
  logic        resetn;
  logic        trace_en;
  logic [1:0]  wb_en;
  logic [63:0] wb_pc;
  logic [9:0]  wb_rd;
  logic [63:0] wb_wdata;
  logic        cpu_stall;
  logic        ref_valid;
  logic        ref_ready;
  logic [31:0] ref_pc;
  logic [4:0]  ref_rd;
  logic [31:0] ref_wdata;
  logic        err;
  logic [1:0]  err_lane;
  logic [31:0] err_pc;
  logic [4:0]  err_rd;
  logic [31:0] err_wdata;
  logic [31:0] err_ref_pc;
  logic        done;
  logic        overflow;
  logic [31:0] checked_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] q_pc[$];
  logic [4:0]  q_rd[$];
  logic [31:0] q_d[$];

  always #5 sys_clk = ~sys_clk;

  wb_trace_checker dut (
    .sys_clk(sys_clk), .resetn(resetn), .trace_en(trace_en),
    .wb_en(wb_en), .wb_pc(wb_pc), .wb_rd(wb_rd), .wb_wdata(wb_wdata),
    .cpu_stall(cpu_stall), .ref_valid(ref_valid), .ref_ready(ref_ready),
    .ref_pc(ref_pc), .ref_rd(ref_rd), .ref_wdata(ref_wdata),
    .err(err), .err_lane(err_lane), .err_pc(err_pc), .err_rd(err_rd),
    .err_wdata(err_wdata), .err_ref_pc(err_ref_pc), .done(done),
    .overflow(overflow), .checked_count(checked_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic set_ref(input logic v, input logic [31:0] pc, input logic [4:0] rd,
                         input logic [31:0] d);
    ref_valid = v;
    ref_pc    = pc;
    ref_rd    = rd;
    ref_wdata = d;
  endtask

  task automatic commit(input logic [1:0] en,
                        input logic [31:0] pc0, input logic [4:0] rd0, input logic [31:0] d0,
                        input logic [31:0] pc1, input logic [4:0] rd1, input logic [31:0] d1);
    wb_en    = en;
    wb_pc    = {pc1, pc0};
    wb_rd    = {rd1, rd0};
    wb_wdata = {d1, d0};
    tick();
    wb_en = 2'b00;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
  endtask

  initial begin
    resetn   = 1'b0;
    trace_en = 1'b1;
    wb_en    = '0;
    wb_pc    = '0;
    wb_rd    = '0;
    wb_wdata = '0;
    set_ref(1'b1, 32'h0, 5'h0, 32'h0);
    tick();
    tick();
    check("rst_err", {31'b0, err}, 0);
    check("rst_done", {31'b0, done}, 0);
    check("rst_ovf", {31'b0, overflow}, 0);
    check("rst_count", checked_count, 0);
    check("rst_ready", {31'b0, ref_ready}, 0);
    check("rst_stall", {31'b0, cpu_stall}, 0);
    resetn = 1'b1;
    set_ref(1'b0, 32'h0, 5'h0, 32'h0);

    // 1: single lane0 commit, matching reference
    set_ref(1'b1, 32'hbfc00000, 5'h01, 32'h00000012);
    #1 check("t1_ready_t", {31'b0, ref_ready}, 0);
    commit(2'b01, 32'hbfc00000, 5'h01, 32'h00000012, 32'h0, 5'h0, 32'h0);
    check("t1_ready_t1", {31'b0, ref_ready}, 1);
    tick();
    set_ref(1'b0, 32'h0, 5'h0, 32'h0);
    check("t1_count", checked_count, 1);
    check("t1_err", {31'b0, err}, 0);

    // 2a: both lanes, references in order
    set_ref(1'b1, 32'hbfc00004, 5'h02, 32'h00000044);
    commit(2'b11, 32'hbfc00004, 5'h02, 32'h00000044, 32'hbfc00008, 5'h03, 32'h00000088);
    tick();
    set_ref(1'b1, 32'hbfc00008, 5'h03, 32'h00000088);
    tick();
    set_ref(1'b0, 32'h0, 5'h0, 32'h0);
    check("t2a_count", checked_count, 3);
    check("t2a_err", {31'b0, err}, 0);

    // 2b: references swapped, first pop mismatches
    set_ref(1'b1, 32'hbfc00008, 5'h03, 32'h00000088);
    commit(2'b11, 32'hbfc00004, 5'h02, 32'h00000044, 32'hbfc00008, 5'h03, 32'h00000088);
    tick();
    check("t2b_err", {31'b0, err}, 1);
    check("t2b_lane", {30'b0, err_lane}, 0);
    check("t2b_pc", err_pc, 32'hbfc00004);
    check("t2b_ref_pc", err_ref_pc, 32'hbfc00008);
    check("t2b_rd", {27'b0, err_rd}, 2);
    check("t2b_count", checked_count, 4);
    check("t2b_ready", {31'b0, ref_ready}, 0);
    set_ref(1'b0, 32'h0, 5'h0, 32'h0);
    do_reset();

    // 3: lane1 data mismatch
    set_ref(1'b1, 32'hbfc00010, 5'h04, 32'h00000006);
    commit(2'b10, 32'h0, 5'h0, 32'h0, 32'hbfc00010, 5'h04, 32'h00000005);
    check("t3_err_t1", {31'b0, err}, 0);
    tick();
    check("t3_err_t2", {31'b0, err}, 1);
    check("t3_lane", {30'b0, err_lane}, 1);
    check("t3_wdata", err_wdata, 32'h00000005);
    check("t3_ready", {31'b0, ref_ready}, 0);
    check("t3_stall", {31'b0, cpu_stall}, 0);
    set_ref(1'b0, 32'h0, 5'h0, 32'h0);
    do_reset();

    // 4: skip window, trace disabled, and just outside the skip window
    set_ref(1'b1, 32'hbfc00384, 5'h05, 32'h00000002);
    commit(2'b01, 32'hbfc00384, 5'h05, 32'h00000001, 32'h0, 5'h0, 32'h0);
    tick();
    check("t4_skip_err", {31'b0, err}, 0);
    check("t4_skip_count", checked_count, 1);
    trace_en = 1'b0;
    set_ref(1'b1, 32'hbfc00020, 5'h05, 32'h00000002);
    commit(2'b01, 32'hbfc00020, 5'h05, 32'h00000001, 32'h0, 5'h0, 32'h0);
    tick();
    trace_en = 1'b1;
    check("t4_off_err", {31'b0, err}, 0);
    check("t4_off_count", checked_count, 2);
    set_ref(1'b1, 32'hbfc00388, 5'h05, 32'h00000002);
    commit(2'b01, 32'hbfc00388, 5'h05, 32'h00000001, 32'h0, 5'h0, 32'h0);
    tick();
    check("t4_edge_err", {31'b0, err}, 1);
    check("t4_edge_pc", err_pc, 32'hbfc00388);
    check("t4_edge_count", checked_count, 3);
    set_ref(1'b0, 32'h0, 5'h0, 32'h0);
    do_reset();

    // 5: fill without pops; stall at 7 entries, overflow when a push does not fit
    commit(2'b01, 32'hbfc01000, 5'd1, 32'd0, 32'h0, 5'h0, 32'h0);
    q_pc.push_back(32'hbfc01000); q_rd.push_back(5'd1); q_d.push_back(32'd0);
    check("t5_stall_1", {31'b0, cpu_stall}, 0);
    for (int k = 1; k <= 3; k++) begin
      commit(2'b11, 32'hbfc01000 + 32'(16*k), 5'(k+1), 32'(2*k),
                    32'hbfc01008 + 32'(16*k), 5'(k+9), 32'(2*k+1));
      q_pc.push_back(32'hbfc01000 + 32'(16*k)); q_rd.push_back(5'(k+1)); q_d.push_back(32'(2*k));
      q_pc.push_back(32'hbfc01008 + 32'(16*k)); q_rd.push_back(5'(k+9)); q_d.push_back(32'(2*k+1));
      check($sformatf("t5_stall_%0d", 2*k+1), {31'b0, cpu_stall}, (k == 3) ? 32'd1 : 32'd0);
    end
    check("t5_ovf_7", {31'b0, overflow}, 0);
    commit(2'b11, 32'hbfc01040, 5'd5, 32'd8, 32'hbfc01048, 5'd13, 32'd9);
    q_pc.push_back(32'hbfc01040); q_rd.push_back(5'd5); q_d.push_back(32'd8);
    check("t5_ovf_full", {31'b0, overflow}, 1);
    check("t5_stall_full", {31'b0, cpu_stall}, 1);
    for (int i = 0; i < q_pc.size(); i++) begin
      set_ref(1'b1, q_pc[i], q_rd[i], q_d[i]);
      tick();
    end
    check("t5_drain_count", checked_count, 8);
    check("t5_drain_err", {31'b0, err}, 0);
    check("t5_empty_ready", {31'b0, ref_ready}, 0);
    set_ref(1'b0, 32'h0, 5'h0, 32'h0);

    // 6: END_PC reference terminates checking, then a one-cycle reset
    set_ref(1'b1, 32'hbfc00100, 5'h1f, 32'hdeadbeef);
    commit(2'b01, 32'hbfc00030, 5'h06, 32'h00000030, 32'h0, 5'h0, 32'h0);
    tick();
    check("t6_done", {31'b0, done}, 1);
    check("t6_count", checked_count, 8);
    check("t6_err", {31'b0, err}, 0);
    set_ref(1'b1, 32'hbfc00040, 5'h07, 32'h00000099);
    commit(2'b01, 32'hbfc00040, 5'h07, 32'h00000001, 32'h0, 5'h0, 32'h0);
    tick();
    check("t6_after_err", {31'b0, err}, 0);
    check("t6_after_count", checked_count, 8);
    check("t6_after_ready", {31'b0, ref_ready}, 0);
    check("t6_after_stall", {31'b0, cpu_stall}, 0);
    do_reset();
    check("t6_rst_done", {31'b0, done}, 0);
    check("t6_rst_ovf", {31'b0, overflow}, 0);
    check("t6_rst_count", checked_count, 0);
    check("t6_rst_ready", {31'b0, ref_ready}, 0);
    set_ref(1'b0, 32'h0, 5'h0, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
